// File: rtl/ysyx_rf_scoreboard.sv
// ysyx_rf_scoreboard: per-register pending-write scoreboard with issue gating and flush drain.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   iss_valid/iss_wen/iss_rd         instruction offered for issue and its destination
//   iss_rs1/iss_rs2, iss_use_rs1/2   source operands and whether they are read
//   iss_ready                        issue accepted when high together with iss_valid
//   fwd_valid/fwd_rd                 execute-stage result available for bypass
//   wb_valid/wb_rd                   register file write committed this cycle
//   flush                            squash request, enters DRAIN until all writes retire
//   rf_table                         bit i set while register i has pending writes
//   hazard                           source operand conflict blocking issue
//   draining                         FSM is in DRAIN
// Configuration: define YSYX_SB_FORWARD_EN to let a single pending write be bypassed
// from the execute stage instead of stalling until writeback.
module ysyx_rf_scoreboard #(
    parameter int NR_REG = 16,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic              iss_wen,
    input  logic [3:0]        iss_rd,
    input  logic [3:0]        iss_rs1,
    input  logic [3:0]        iss_rs2,
    input  logic              iss_use_rs1,
    input  logic              iss_use_rs2,
    output logic              iss_ready,
    input  logic              fwd_valid,
    input  logic [3:0]        fwd_rd,
    input  logic              wb_valid,
    input  logic [3:0]        wb_rd,
    input  logic              flush,
    output logic [NR_REG-1:0] rf_table,
    output logic              hazard,
    output logic              draining
);
    typedef enum logic {RUN, DRAIN} state_t;
    localparam logic [CNT_W-1:0] CMAX = '1;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt [NR_REG];
    logic [NR_REG-1:0] inc_v, dec_v;
    logic              fwd1, fwd2, fire;
`ifdef YSYX_SB_FORWARD_EN
    // Bypass only covers the youngest write, so it is safe only with exactly one pending.
    assign fwd1 = fwd_valid & (fwd_rd == iss_rs1) & (cnt[iss_rs1] == CNT_W'(1));
    assign fwd2 = fwd_valid & (fwd_rd == iss_rs2) & (cnt[iss_rs2] == CNT_W'(1));
`else
    logic unused_fwd;
    assign unused_fwd = fwd_valid ^ (^fwd_rd);
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    always_comb begin
        rf_table = '0;
        for (int i = 0; i < NR_REG; i++) rf_table[i] = cnt[i] != '0;
        // Counter 0 never leaves zero, so rf_table[0] already encodes "x0 never busy".
        hazard    = iss_valid & ((iss_use_rs1 & rf_table[iss_rs1] & ~fwd1) |
                                 (iss_use_rs2 & rf_table[iss_rs2] & ~fwd2));
        iss_ready = ~hazard & ~(iss_wen & (cnt[iss_rd] == CMAX)) & (state_q == RUN) & ~flush;
        fire      = iss_valid & iss_ready;
        inc_v     = '0;
        dec_v     = '0;
        inc_v[iss_rd] = fire & iss_wen & (iss_rd != '0);
        // A writeback to an idle register is spurious and must not wrap the counter.
        dec_v[wb_rd]  = wb_valid & (wb_rd != '0) & rf_table[wb_rd];
        state_d   = flush ? DRAIN : (state_q == DRAIN && rf_table == '0) ? RUN : state_q;
        draining  = state_q == DRAIN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            for (int i = 0; i < NR_REG; i++) cnt[i] <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NR_REG; i++)
                if (inc_v[i] ^ dec_v[i]) cnt[i] <= inc_v[i] ? cnt[i] + CNT_W'(1) : cnt[i] - CNT_W'(1);
        end
    end
endmodule
